div_32: RTL and testbench

DIV_32 -- requirements
Module: div_32

---
 rtl/div_32_pkg.sv | 19 +
 rtl/add_32.sv | 12 +
 rtl/div_32.sv | 126 ++++++++++++
 tb/tb_div_32.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/div_32_pkg.sv
// div_32_pkg: shared divider state encoding, sizing constants and helpers
package div_32_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    // magnitude of a two's-complement value; 0x80000000 maps to 2^31 read as unsigned
    function automatic logic [DIV_WIDTH-1:0] abs32(input logic [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/add_32.sv
// add_32: 32-bit adder with carry in and carry out
module add_32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + 33'(i_cin);

endmodule

// File: rtl/div_32.sv
// div_32: signed 32-bit radix-2 non-restoring divider, 34-cycle latency
module div_32 import div_32_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [4:0]       r_cnt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_a;
    logic             r_neg_b;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz;
    logic             w_zero;
    logic             w_sub;
    logic [WIDTH:0]   w_p_sh;
    logic [WIDTH:0]   w_p_new;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_rem_mag;

    assign w_zero = divisor == '0;

    // RUN: shift {P,Q} left, then subtract D if P was non-negative, else add D.
    // FIXUP: the same adder restores a negative final remainder by adding D.
    // The 33rd bit of P is formed from the 32-bit adder's carry out.
    assign w_p_sh    = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_sub     = ~r_p[WIDTH];
    assign w_add_a   = (r_state == FIXUP) ? r_p[WIDTH-1:0] : w_p_sh[WIDTH-1:0];
    assign w_add_b   = (r_state == FIXUP || !w_sub) ? r_dvs : ~r_dvs;
    assign w_cin     = (r_state != FIXUP) && w_sub;
    assign w_p_new   = {w_p_sh[WIDTH] ^ w_sub ^ w_cout, w_sum};
    assign w_rem_mag = r_p[WIDTH] ? w_sum : r_p[WIDTH-1:0];

    add_32 u_add (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // next-state: divide-by-zero skips straight to DONE; DONE always returns to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start) w_next = w_zero ? DONE : RUN;
            RUN:   if (r_cnt == 5'(DIV_ITERS - 1)) w_next = FIXUP;
            FIXUP: w_next = DONE;
            DONE:  w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock) begin
        if (clear) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // datapath: latch magnitudes and signs on accept, iterate, sign-correct into result registers
    always_ff @(posedge clock) begin
        if (clear) begin
            r_cnt   <= '0;
            r_p     <= '0;
            r_q     <= '0;
            r_dvs   <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    if (w_zero) begin
                        r_quo <= '1;
                        r_rem <= dividend;
                        r_dz  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_p     <= '0;
                        r_q     <= abs32(dividend);
                        r_dvs   <= abs32(divisor);
                        r_neg_a <= dividend[WIDTH-1];
                        r_neg_b <= divisor[WIDTH-1];
                    end
                end
                RUN: begin
                    r_p   <= w_p_new;
                    r_q   <= {r_q[WIDTH-2:0], ~w_p_new[WIDTH]};
                    r_cnt <= r_cnt + 5'd1;
                end
                FIXUP: begin
                    r_quo <= (r_neg_a ^ r_neg_b) ? -r_q : r_q;
                    r_rem <= r_neg_a ? -w_rem_mag : w_rem_mag;
                    r_dz  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_state != IDLE;
    assign done        = r_state == DONE;
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_div_32.sv
// tb_div_32: directed vectors against a cycle-timeline arithmetic model of div_32
module tb_div_32;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    int          m_left;
    logic        m_done;
    logic [31:0] m_q;
    logic [31:0] m_r;
    logic        m_dz;
    logic [31:0] p_q;
    logic [31:0] p_r;
    logic        p_dz;

    div_32 dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // signed division with truncation toward zero; divisor 0 gives all-ones / dividend
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint la;
        longint lb;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = 32'(la / lb);
            r  = 32'(la % lb);
            dz = 1'b0;
        end
    endfunction

    // timeline model: m_left counts the cycles the unit still has to stay busy
    always @(posedge clock) begin
        if (clear) begin
            m_left = 0;
            m_done = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_dz   = 1'b0;
        end else if (m_left == 0) begin
            m_done = 1'b0;
            if (start) begin
                model(dividend, divisor, p_q, p_r, p_dz);
                if (divisor == 0) begin
                    m_q    = p_q;
                    m_r    = p_r;
                    m_dz   = p_dz;
                    m_done = 1'b1;
                    m_left = 1;
                end else begin
                    m_left = 34;
                end
            end
        end else begin
            m_left--;
            m_done = m_left == 1;
            if (m_done) begin
                m_q  = p_q;
                m_r  = p_r;
                m_dz = p_dz;
            end
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        if (chk_en) begin
            chk("cyc_busy", 32'(busy), 32'(m_left > 0));
            chk("cyc_done", 32'(done), 32'(m_done));
            chk("cyc_quotient", quotient, m_q);
            chk("cyc_remainder", remainder, m_r);
            chk("cyc_div_by_zero", 32'(div_by_zero), 32'(m_dz));
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz,
                          input int edn, input int inj, input int clr);
        int n;
        int dn;
        int bc;
        n  = 0;
        dn = 0;
        bc = 0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        while (n < 100) begin
            @(posedge clock);
            #1;
            n++;
            if (n == 1) start = 1'b0;
            if (inj != 0 && n == inj) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end
            if (inj != 0 && n == inj + 1) start = 1'b0;
            if (clr != 0 && n == clr) clear = 1'b1;
            if (clr != 0 && n == clr + 1) begin
                clear = 1'b0;
                break;
            end
            if (busy) bc++;
            if (done && dn == 0) dn = n;
            if (!busy) break;
        end
        if (n >= 100) chk("timeout", 32'(n), 32'd0);
        if (clr == 0) begin
            chk("latency", 32'(dn), 32'(edn));
            chk("busy_cycles", 32'(bc), 32'(edn));
            chk("quotient", quotient, eq);
            chk("remainder", remainder, er);
            chk("div_by_zero", 32'(div_by_zero), 32'(edz));
        end
    endtask

    initial begin
        logic [31:0] tq;
        logic [31:0] tr;
        logic        tdz;
        #100000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] tq;
        logic [31:0] tr;
        logic        tdz;
        model(32'd100, 32'd7, tq, tr, tdz);
        chk("pin_100_7_q", tq, 32'd14);
        chk("pin_100_7_r", tr, 32'd2);
        model(32'hFFFFFF9C, 32'd7, tq, tr, tdz);
        chk("pin_m100_7_r", tr, 32'hFFFFFFFE);
        model(32'h80000000, 32'hFFFFFFFF, tq, tr, tdz);
        chk("pin_min_m1_q", tq, 32'h80000000);
        clear    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clock);
        #1;
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        clear = 1'b0;
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 0, 0);
        run_op(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34, 0, 0);
        run_op(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 34, 0, 0);
        run_op(32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 34, 0, 0);
        run_op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 34, 0, 0);
        run_op(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1, 0, 0);
        run_op(32'd6, 32'd3, 32'd2, 32'd0, 1'b0, 34, 0, 0);
        run_op(32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, 34, 0, 0);
        run_op(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 34, 0, 0);
        run_op(32'h7FFFFFFF, 32'h80000000, 32'd0, 32'h7FFFFFFF, 1'b0, 34, 0, 0);
        run_op(32'h80000000, 32'h80000000, 32'd1, 32'd0, 1'b0, 34, 0, 0);
        run_op(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 34, 0, 0);
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 5, 0);
        run_op(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 0, 0, 10);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        chk("abort_div_by_zero", 32'(div_by_zero), 32'd0);
        run_op(32'd42, 32'd5, 32'd8, 32'd2, 1'b0, 34, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
